// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP add/sub arbiter.
package fpu_pkg;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } fpu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } ctrl_state_e;

    localparam logic [31:0] FPU_QNAN = 32'h7FC00000;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after last_grant wins.
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last_grant,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_idx,
    output logic                    any
);

    localparam int          IDW = $clog2(NREQ);
    localparam int unsigned N   = NREQ;

    logic [IDW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            idx = IDW'((32'(last_grant) + off) % N);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/fpu_rr_arbiter.sv
// Round-robin arbiter sharing one FP add/sub unit among NREQ requesters,
// one operation in flight, with a wait timeout that forces a qNaN error response.
module fpu_rr_arbiter
    import fpu_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ-1:0]         req_op,
    input  logic [NREQ*32-1:0]      req_a,
    input  logic [NREQ*32-1:0]      req_b,
    output logic                    fpu_valid,
    output logic                    fpu_op,
    output logic [31:0]             fpu_a,
    output logic [31:0]             fpu_b,
    input  logic                    fpu_done,
    input  logic [31:0]             fpu_result,
    input  logic                    fpu_error,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [31:0]             rsp_result,
    output logic                    rsp_error,
    output logic                    rsp_timeout
);

    localparam int          IDW = $clog2(NREQ);
    localparam int unsigned N   = NREQ;

    ctrl_state_e    state_q, state_d;
    logic [7:0]     wait_cnt;
    logic [IDW-1:0] last_grant;
    fpu_op_e        op_q;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            any_req;
    logic [31:0]     sel_a, sel_b;
    logic            sel_op;
    logic            timeout_hit;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any        (any_req)
    );

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_a  = req_a[32*i +: 32];
                sel_b  = req_b[32*i +: 32];
                sel_op = req_op[i];
            end
        end
    end

    // Compare the post-increment count so the response lands TIMEOUT cycles after entering WAIT.
    assign timeout_hit = (wait_cnt + 8'd1) == 8'(TIMEOUT);

    assign req_ready = (state_q == IDLE && !rst) ? grant : '0;
    assign fpu_valid = (state_q == ISSUE);
    assign rsp_valid = (state_q == RESP);
    assign fpu_op    = op_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (fpu_done || timeout_hit) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt    <= '0;
            last_grant  <= IDW'(NREQ - 1);
            op_q        <= ADD;
            fpu_a       <= '0;
            fpu_b       <= '0;
            rsp_id      <= '0;
            rsp_result  <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        fpu_a  <= sel_a;
                        fpu_b  <= sel_b;
                        op_q   <= fpu_op_e'(sel_op);
                        rsp_id <= grant_idx;
                    end
                end
                ISSUE: wait_cnt <= '0;
                WAIT: begin
                    if (fpu_done) begin
                        rsp_result  <= fpu_result;
                        rsp_error   <= fpu_error;
                        rsp_timeout <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_result  <= FPU_QNAN;
                        rsp_error   <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: if (rsp_ready) last_grant <= rsp_id;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_rr_arbiter.sv
// Self-checking bench for fpu_rr_arbiter: vector table plus reset/timeout sequences.
module tb_fpu_rr_arbiter;

    localparam int TIMEOUT = 15;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid, req_ready, req_op;
    logic [127:0] req_a, req_b;
    logic         fpu_valid, fpu_op;
    logic [31:0]  fpu_a, fpu_b;
    logic         fpu_done;
    logic [31:0]  fpu_result;
    logic         fpu_error;
    logic         rsp_valid, rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_result;
    logic         rsp_error, rsp_timeout;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  mask;
        logic [1:0]  exp_id;
        int          delay;   // WAIT cycle index of fpu_done; -1 = never
        logic [31:0] res;
        logic        err;
        int          hold;    // cycles rsp_ready held low in RESP
    } vec_t;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] res;
        logic        err;
        logic        tmo;
    } rsp_t;

    vec_t        vecs[12];
    rsp_t        sb[$];
    logic [31:0] opa[4];
    logic [31:0] opb[4];
    logic        opo[4];

    fpu_rr_arbiter #(.NREQ(4), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .fpu_valid   (fpu_valid),
        .fpu_op      (fpu_op),
        .fpu_a       (fpu_a),
        .fpu_b       (fpu_b),
        .fpu_done    (fpu_done),
        .fpu_result  (fpu_result),
        .fpu_error   (fpu_error),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_error   (rsp_error),
        .rsp_timeout (rsp_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"},   32'(req_ready),   32'd0);
        chk({tag, "_fpu_valid"},   32'(fpu_valid),   32'd0);
        chk({tag, "_rsp_valid"},   32'(rsp_valid),   32'd0);
        chk({tag, "_rsp_error"},   32'(rsp_error),   32'd0);
        chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
        chk({tag, "_rsp_id"},      32'(rsp_id),      32'd0);
        chk({tag, "_rsp_result"},  rsp_result,       32'd0);
        chk({tag, "_fpu_a"},       fpu_a,            32'd0);
        chk({tag, "_fpu_b"},       fpu_b,            32'd0);
        chk({tag, "_fpu_op"},      32'(fpu_op),      32'd0);
    endtask

    task automatic run_op(input vec_t v);
        rsp_t       e;
        int         k;
        logic [1:0] id;
        logic [3:0] oh;
        id = v.exp_id;
        oh = 4'b0001 << id;
        req_valid = v.mask;
        #1;
        chk("grant_onehot", 32'(req_ready), 32'(oh));
        chk("fpu_valid_idle", 32'(fpu_valid), 32'd0);
        tick();
        req_valid = '0;
        #1;
        chk("fpu_valid_issue", 32'(fpu_valid), 32'd1);
        chk("fpu_a_issue", fpu_a, opa[id]);
        chk("fpu_b_issue", fpu_b, opb[id]);
        chk("fpu_op_issue", 32'(fpu_op), 32'(opo[id]));
        chk("req_ready_issue", 32'(req_ready), 32'd0);
        tick();
        chk("fpu_valid_wait", 32'(fpu_valid), 32'd0);
        if (v.delay < 0) begin
            for (k = 0; k < 40; k++) begin
                if (rsp_valid) break;
                tick();
            end
            chk("timeout_latency", 32'(k), 32'(TIMEOUT));
            sb.push_back('{id, 32'h7FC00000, 1'b1, 1'b1});
        end else begin
            repeat (v.delay) tick();
            chk("rsp_early", 32'(rsp_valid), 32'd0);
            chk("fpu_a_hold", fpu_a, opa[id]);
            fpu_done   = 1'b1;
            fpu_result = v.res;
            fpu_error  = v.err;
            sb.push_back('{id, v.res, v.err, 1'b0});
            tick();
            fpu_done   = 1'b0;
            fpu_result = 32'hDEADBEEF;
            fpu_error  = 1'b0;
            #1;
            chk("rsp_latency", 32'(rsp_valid), 32'd1);
        end
        for (int h = 0; h < v.hold; h++) begin
            req_valid = v.mask;
            if (h == 2) begin
                fpu_done   = 1'b1;
                fpu_result = 32'h12345678;
                fpu_error  = 1'b1;
            end
            #1;
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_fpu_valid", 32'(fpu_valid), 32'd0);
            if (sb.size() > 0) begin
                chk("hold_rsp_id", 32'(rsp_id), 32'(sb[0].id));
                chk("hold_rsp_result", rsp_result, sb[0].res);
                chk("hold_rsp_error", 32'(rsp_error), 32'(sb[0].err));
            end
            tick();
            fpu_done = 1'b0;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            chk("rsp_result", rsp_result, e.res);
            chk("rsp_error", 32'(rsp_error), 32'(e.err));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
        end
        tick();
        rsp_ready = 1'b0;
        #1;
        chk("rsp_release", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        vec_t tail;
        opa[0] = 32'h3F800000; opb[0] = 32'h40000000; opo[0] = 1'b0;
        opa[1] = 32'h40400000; opb[1] = 32'h3F800000; opo[1] = 1'b1;
        opa[2] = 32'h41200000; opb[2] = 32'h40A00000; opo[2] = 1'b0;
        opa[3] = 32'hC0000000; opb[3] = 32'h40000000; opo[3] = 1'b1;

        vecs[0]  = '{4'b1111, 2'd0,  0, 32'h40400000, 1'b0, 0};
        vecs[1]  = '{4'b1111, 2'd1,  2, 32'h40000000, 1'b0, 0};
        vecs[2]  = '{4'b1111, 2'd2,  0, 32'h41700000, 1'b0, 0};
        vecs[3]  = '{4'b1111, 2'd3,  3, 32'hC0800000, 1'b0, 0};
        vecs[4]  = '{4'b1111, 2'd0,  1, 32'h40400000, 1'b0, 0};
        vecs[5]  = '{4'b0001, 2'd0,  0, 32'h40400000, 1'b0, 0};
        vecs[6]  = '{4'b1010, 2'd1,  0, 32'h40000000, 1'b0, 0};
        vecs[7]  = '{4'b1010, 2'd3,  4, 32'hC0800000, 1'b0, 0};
        vecs[8]  = '{4'b0100, 2'd2, -1, 32'h00000000, 1'b0, 0};
        vecs[9]  = '{4'b1001, 2'd3,  1, 32'h7FC00000, 1'b1, 5};
        vecs[10] = '{4'b1001, 2'd0, 14, 32'h40400000, 1'b0, 0};
        vecs[11] = '{4'b1111, 2'd1, 13, 32'h40000000, 1'b0, 1};

        for (int i = 0; i < 4; i++) begin
            req_a[32*i +: 32] = opa[i];
            req_b[32*i +: 32] = opb[i];
            req_op[i]         = opo[i];
        end
        rst        = 1'b1;
        req_valid  = 4'b1111;
        fpu_done   = 1'b0;
        fpu_result = '0;
        fpu_error  = 1'b0;
        rsp_ready  = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        req_valid = '0;
        rst = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) run_op(vecs[i]);

        // Reset during WAIT, then a stale fpu_done must be ignored.
        req_valid = 4'b0100;
        #1;
        chk("midrst_grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        fpu_done   = 1'b1;
        fpu_result = 32'h3F800000;
        tick();
        fpu_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        chk_all_zero("midrst");
        tail = '{4'b1111, 2'd0, 2, 32'h40800000, 1'b0, 0};
        run_op(tail);

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover actual=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_rr_arbiter.md
FPU_RR_ARBITER -- requirements
Module: fpu_rr_arbiter

Interface
REQ-001 Parameter NREQ, default 4, meaning number of requesters sharing one FP add/sub unit (2..8).
REQ-002 Parameter TIMEOUT, default 15, meaning maximum cycles in WAIT before a forced error response (1..255).
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  NREQ  per-requester request valid.
REQ-006 req_ready  output  NREQ  per-requester accept, at most one bit high per cycle.
REQ-007 req_op  input  NREQ  per-requester op: 0 = add, 1 = subtract (a-b).
REQ-008 req_a, req_b  input  NREQ*32 each  flattened IEEE-754 operands; requester i uses bits [32i+31:32i].
REQ-009 fpu_valid  output  1  one-cycle start pulse to the FP unit.
REQ-010 fpu_op  output  1  op for the issued operation.
REQ-011 fpu_a, fpu_b  output  32 each  operands for the issued operation.
REQ-012 fpu_done  input  1  one-cycle completion pulse from the FP unit.
REQ-013 fpu_result  input  32  FP unit result, valid when fpu_done=1.
REQ-014 fpu_error  input  1  FP unit invalid-operation flag, valid when fpu_done=1.
REQ-015 rsp_valid  output  1  response valid.
REQ-016 rsp_ready  input  1  response consumer ready.
REQ-017 rsp_id  output  $clog2(NREQ)  index of the requester this response belongs to.
REQ-018 rsp_result  output  32  result word.
REQ-019 rsp_error, rsp_timeout  output  1 each  error flag; timeout flag.

Function
REQ-020 The controller SHALL use states IDLE, ISSUE, WAIT, RESP with exactly one operation in flight.
REQ-021 IDLE: when any req_valid is high, the controller SHALL assert req_ready for exactly one requester, chosen round-robin starting at index (last_grant+1) mod NREQ, latch its id, op and operands, and go to ISSUE.
REQ-022 req_ready SHALL be high only in IDLE and only for a requester whose req_valid is high.
REQ-023 ISSUE: fpu_valid SHALL be 1 for exactly this one cycle with the latched operands on fpu_op/fpu_a/fpu_b; next state WAIT, wait counter cleared to 0.
REQ-024 fpu_a, fpu_b and fpu_op SHALL hold the latched values from ISSUE until the next grant.
REQ-025 WAIT: on fpu_done=1 the controller SHALL latch fpu_result and fpu_error, set rsp_timeout=0, and go to RESP.
REQ-026 WAIT: the counter SHALL increment each cycle without fpu_done; in the cycle it equals TIMEOUT the controller SHALL load rsp_result=32'h7FC00000, rsp_error=1, rsp_timeout=1 and go to RESP.
REQ-027 If fpu_done and the timeout condition occur in the same cycle, fpu_done SHALL take priority.
REQ-028 fpu_done in any state other than WAIT SHALL be ignored.
REQ-029 RESP: rsp_valid SHALL be 1 and rsp_id/rsp_result/rsp_error/rsp_timeout SHALL be stable until rsp_ready=1; on that handshake last_grant SHALL update to rsp_id and the state SHALL go to IDLE.
REQ-030 Minimum latency: request accepted cycle T, fpu_valid at T+1, rsp_valid in the cycle after fpu_done.
REQ-031 A requester dropping req_valid after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-032 On rst the controller SHALL enter IDLE, clear the wait counter, set last_grant=NREQ-1 (requester 0 first), and drive req_ready=0, fpu_valid=0, rsp_valid=0, rsp_error=0, rsp_timeout=0, rsp_id=0, rsp_result=0, fpu_a=0, fpu_b=0, fpu_op=0.
REQ-033 rst asserted mid-operation SHALL abandon the operation with no response, and a later fpu_done SHALL be ignored.

Structure
REQ-034 Package fpu_pkg SHALL hold the op typedef (ADD=0, SUB=1), the controller state enum, and the constant FPU_QNAN=32'h7FC00000.
REQ-035 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs: request vector, last_grant; outputs: one-hot grant, grant index, any).

Verification
REQ-036 Single request: req 0, add 3F800000+40000000 -> fpu_valid one cycle later with the same operands; fpu_done result 40400000 -> rsp_id=0, rsp_result=40400000, rsp_error=0.
REQ-037 All four requesters held valid after reset -> grant order 0,1,2,3,0 across five consecutive operations.
REQ-038 No fpu_done with TIMEOUT=15 -> rsp_valid exactly 15 cycles after entering WAIT, rsp_result=7FC00000, rsp_error=1, rsp_timeout=1.
REQ-039 Hold rsp_ready=0 for 5 cycles in RESP -> rsp outputs stable, req_ready=0, no fpu_valid pulse; release -> next grant next cycle.
REQ-040 Assert rst during WAIT, then pulse fpu_done -> no rsp_valid, all outputs 0, next request granted to requester 0.
